// File: rtl/sdu_pkg.sv
// Shared SDUltrasound definitions: sequencer states, sample width and the pipeline flags
// carried from the sequencer to the output registers.
package sdu_pkg;

  localparam int unsigned SDU_SAMPLE_W = 16;
  localparam int unsigned SDU_MIN_GAP  = 2;
  localparam int unsigned SDU_CNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRE   = 2'd1,
    LISTEN = 2'd2,
    GAP    = 2'd3
  } sdu_state_e;

  typedef struct packed {
    logic fire;
    logic listen;
    logic seq_last;
    logic run_last;
    logic active;
  } sdu_pipe_t;

endpackage

// File: rtl/ram.sv
// Inferred simple dual-port RAM: one write port, one registered read port.
module ram #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [2**AWIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sdu_tx.sv
// Transmit sequencer: fires the stored waveform to the DAC, opens a receive window,
// and repeats for the programmed number of averaging sequences.
module sdu_tx
  import sdu_pkg::*;
#(
  parameter int unsigned AWIDTH     = 10,
  parameter int unsigned DWIDTH     = SDU_SAMPLE_W,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          sdu_tx_data,
  input  logic                 sdu_tx_strobe,
  input  logic                 sdu_tx_wr_reset,
  input  logic [AWIDTH:0]      cfg_wave_len,
  input  logic [SDU_CNT_W-1:0] cfg_listen_len,
  input  logic [SDU_CNT_W-1:0] cfg_num_ave,
  input  logic                 start,
  output logic [DWIDTH-1:0]    dac_out,
  output logic                 sdu_rx_en,
  output logic                 sdu_seq_done_strobe,
  output logic                 sdu_ave_done_strobe,
  output logic                 busy,
  output logic [SDU_CNT_W-1:0] seq_count
);

  localparam int unsigned GAP_EFF = (GAP_CYCLES < SDU_MIN_GAP) ? SDU_MIN_GAP : GAP_CYCLES;
  // Gap state spans the gap plus the two-stage read pipeline, so sample 0 of the next
  // sequence lands GAP_CYCLES+2 cycles after the receive window closes.
  localparam logic [SDU_CNT_W-1:0] GAP_LAST = SDU_CNT_W'(GAP_EFF + 1);
  localparam logic [AWIDTH:0]      WLEN_ONE = (AWIDTH+1)'(1);

  sdu_state_e           state;
  logic [AWIDTH-1:0]    rd_addr;
  logic [AWIDTH-1:0]    wr_idx;
  logic [AWIDTH-1:0]    wave_last;
  logic                 wave_zero;
  logic [SDU_CNT_W-1:0] listen_cnt;
  logic [SDU_CNT_W-1:0] listen_last;
  logic [SDU_CNT_W-1:0] gap_cnt;
  logic [SDU_CNT_W-1:0] seq_num;
  logic [SDU_CNT_W-1:0] ave_last;
  logic [DWIDTH-1:0]    ram_q;
  logic                 idle_c;
  logic                 wr_en_c;
  logic                 unused_hi;
  sdu_pipe_t            p0;
  sdu_pipe_t            p1;

  assign idle_c    = (state == IDLE) && !busy;
  assign wr_en_c   = sdu_tx_strobe && !sdu_tx_wr_reset && idle_c;
  assign unused_hi = ^sdu_tx_data[31:DWIDTH];

  ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH)) u_ram (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr (wr_idx),
    .wdata (sdu_tx_data[DWIDTH-1:0]),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  // Host write index
  always_ff @(posedge clk) begin
    if (reset || sdu_tx_wr_reset) wr_idx <= '0;
    else if (wr_en_c)             wr_idx <= wr_idx + AWIDTH'(1);
  end

  // Sequencer flags for the current state, delayed later to align with the RAM read
  always_comb begin
    p0          = '0;
    p0.fire     = (state == FIRE);
    p0.listen   = (state == LISTEN);
    p0.seq_last = p0.listen && (listen_cnt == listen_last);
    p0.run_last = p0.seq_last && (seq_num == ave_last);
    p0.active   = (state != IDLE);
  end

  // Fire/listen/gap sequencer
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rd_addr     <= '0;
      wave_last   <= '0;
      wave_zero   <= 1'b0;
      listen_cnt  <= '0;
      listen_last <= '0;
      gap_cnt     <= '0;
      seq_num     <= '0;
      ave_last    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !busy) begin
            wave_zero   <= (cfg_wave_len == '0);
            wave_last   <= AWIDTH'(cfg_wave_len - WLEN_ONE);
            listen_last <= (cfg_listen_len == '0) ? '0 : cfg_listen_len - SDU_CNT_W'(1);
            ave_last    <= (cfg_num_ave == '0) ? '0 : cfg_num_ave - SDU_CNT_W'(1);
            rd_addr     <= '0;
            listen_cnt  <= '0;
            seq_num     <= '0;
            state       <= (cfg_wave_len == '0) ? LISTEN : FIRE;
          end
        end
        FIRE: begin
          if (rd_addr == wave_last) begin
            listen_cnt <= '0;
            state      <= LISTEN;
          end else begin
            rd_addr <= rd_addr + AWIDTH'(1);
          end
        end
        LISTEN: begin
          if (listen_cnt == listen_last) begin
            if (seq_num == ave_last) begin
              state <= IDLE;
            end else begin
              gap_cnt <= '0;
              seq_num <= seq_num + SDU_CNT_W'(1);
              state   <= GAP;
            end
          end else begin
            listen_cnt <= listen_cnt + SDU_CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            rd_addr    <= '0;
            listen_cnt <= '0;
            state      <= wave_zero ? LISTEN : FIRE;
          end else begin
            gap_cnt <= gap_cnt + SDU_CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output registers, one stage behind the RAM read
  always_ff @(posedge clk) begin
    if (reset) begin
      p1                  <= '0;
      dac_out             <= '0;
      sdu_rx_en           <= 1'b0;
      sdu_seq_done_strobe <= 1'b0;
      sdu_ave_done_strobe <= 1'b0;
      busy                <= 1'b0;
      seq_count           <= '0;
    end else begin
      p1                  <= p0;
      dac_out             <= p1.fire ? ram_q : '0;
      sdu_rx_en           <= p1.listen;
      sdu_seq_done_strobe <= p1.seq_last;
      sdu_ave_done_strobe <= p1.run_last;
      busy                <= p0.active || p1.active;
      if (start && idle_c)          seq_count <= '0;
      else if (sdu_seq_done_strobe) seq_count <= seq_count + SDU_CNT_W'(1);
    end
  end

endmodule

// File: doc/sdu_tx.md
# sdu_tx

Transmit-side sequencer for SDUltrasound. It holds a host-loaded excitation waveform in on-chip RAM, fires it to the DAC, then opens a receive window. It repeats this fire/listen cycle for a programmed number of averaging sequences. It generates the `sdu_rx_en`, `sdu_seq_done_strobe` and `sdu_ave_done_strobe` control signals consumed by the receive/averaging block, and sits between the host control path and the DAC.

## Interface
- `AWIDTH`, default 10: waveform RAM address width; depth is 2^AWIDTH samples.
- `DWIDTH`, default 16: DAC sample width.
- `GAP_CYCLES`, default 4: idle cycles between sequences; minimum 2, so the receiver can return to its reset state.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `sdu_tx_data` in 32: host write word; bits [DWIDTH-1:0] are the sample, upper bits are ignored.
- `sdu_tx_strobe` in 1: write `sdu_tx_data` at the write index, then increment the index.
- `sdu_tx_wr_reset` in 1: write index returns to 0 on the next cycle; takes priority over `sdu_tx_strobe`.
- `cfg_wave_len` in AWIDTH+1: samples to fire per sequence, 0..2^AWIDTH.
- `cfg_listen_len` in 16: receive-window length in cycles; 0 is treated as 1.
- `cfg_num_ave` in 16: number of sequences; 0 is treated as 1.
- `start` in 1: one-cycle strobe that begins a run.
- `dac_out` out DWIDTH: registered DAC sample.
- `sdu_rx_en` out 1: receive window active.
- `sdu_seq_done_strobe` out 1: one cycle, at the end of each sequence.
- `sdu_ave_done_strobe` out 1: one cycle, at the end of the final sequence.
- `busy` out 1: a run is in progress.
- `seq_count` out 16: number of sequences completed in the current or last run.

## Operation
- **Write path**
  - Active only when state is IDLE; `sdu_tx_strobe` while busy is ignored and the index does not move.
  - Write index wraps modulo 2^AWIDTH.
  - RAM contents are never cleared, including by `reset`.
- **Start**
  - `start` in IDLE latches `cfg_*`, clears `seq_count`, and enters FIRE.
  - `start` while busy is ignored.
  - Configuration changes during a run have no effect on that run.
- **States**
  - IDLE: `dac_out`=0, `sdu_rx_en`=0, `busy`=0.
  - FIRE: read addresses 0..wave_len-1, one per cycle, and drive them onto `dac_out`. If wave_len=0, go straight to LISTEN.
  - LISTEN: `sdu_rx_en`=1 for listen_len cycles, with `dac_out`=0.
  - GAP: GAP_CYCLES cycles with every output low, then FIRE.
- **End of sequence**
  - On the last LISTEN cycle, `sdu_seq_done_strobe`=1 and `seq_count` increments on the following edge.
  - If that sequence is number num_ave, `sdu_ave_done_strobe`=1 in the same cycle, and the next state is IDLE instead of GAP.
- **Widths**
  - Listen and gap counters are 16 bits; the sequence counter is 16 bits.
  - Compare counters against the latched length minus 1; no counter may overflow.
- **Reset mid-run**: all outputs are 0 on the cycle after `reset` is sampled, state is IDLE, write index is 0, and `seq_count` is 0.

## Timing
- **Reset values**: `dac_out`=0, `sdu_rx_en`=0, both strobes 0, `busy`=0, `seq_count`=0.
- **RAM**: registered read, 1-cycle latency.
- **First sample**: `start` sampled at edge t gives `busy`=1 from t+1 and sample k on `dac_out` at t+2+k.
- **Receive window**: `sdu_rx_en` is high from t+2+W to t+1+W+L, where W=wave_len and L=listen_len. When W=0, `sdu_rx_en` rises at t+2.
- **Strobes**: both strobes are coincident with the last `sdu_rx_en`=1 cycle and are never asserted outside a high `sdu_rx_en`.
- **Next sequence**: the next sequence's sample 0 appears GAP_CYCLES+2 cycles after `sdu_rx_en` falls (GAP cycles plus the RAM read pipeline).
- **End of run**: `busy` falls on the cycle after `sdu_ave_done_strobe`. The host must not restart until the receiver's playback completes, which takes listen_len+2 cycles.

## Structure
- Shared package `sdu_pkg`:
  - state encoding: IDLE, FIRE, LISTEN, GAP;
  - `SDU_MIN_GAP`=2;
  - sample-width constant shared with the receiver.
- One sub-module: the existing inferred dual-port `ram`, instantiated with DWIDTH data and AWIDTH address. Host write port; sequencer read port.
- FSM, counters and output registers are in `sdu_tx` itself.

## Test plan
- Load 0x0001, 0x0002, 0x7FFF, 0x8000. Set wave_len=4, listen=8, num_ave=1, and `start` at t. Required:
  - `dac_out` = 1, 2, 7FFF, 8000 at t+2..t+5;
  - `sdu_rx_en` high at t+6..t+13;
  - both strobes at t+13;
  - `busy`=0 at t+14;
  - `seq_count`=1.
- Set num_ave=3, GAP_CYCLES=4. Required:
  - three bursts;
  - `sdu_seq_done_strobe` three times;
  - `sdu_ave_done_strobe` only with the third;
  - sample 0 six cycles after each `sdu_rx_en` fall;
  - `seq_count`=3.
- Set wave_len=0, listen=0, num_ave=0. Required:
  - `dac_out` stays 0;
  - `sdu_rx_en` high for exactly 1 cycle at t+2, with both strobes;
  - `busy` clear at t+3.
- Pulse `start` and `sdu_tx_strobe` (data 0xDEAD) during LISTEN. Required: the run is unaffected, the RAM is unchanged, and a second run replays the identical waveform.
- Assert `reset` mid-LISTEN. Required:
  - all outputs 0 on the next cycle;
  - after reset, `start` replays the previously loaded samples unchanged.
- Write 2^AWIDTH+1 words with value = index. Required: address 0 holds 2^AWIDTH, address 1 holds 1, and `sdu_tx_wr_reset` then makes the next write land at address 0.
